// File: rtl/token_multiplier.sv
// Serial token multiplier: every accepted '1' on a produces an effective
// factor's worth of tokens on b. Tokens that cannot leave in the same cycle
// are held in a pending counter. At most one token leaves per cycle, and only
// when out_ready is high. If the backlog would exceed MAX_PENDING, a sticky
// overflow flag is set and the surplus tokens are dropped.
module token_multiplier #(
    parameter int MAX_FACTOR  = 4,
    parameter int MAX_PENDING = 200,
    parameter int FACT_W      = $clog2(MAX_FACTOR + 1),
    parameter int PEND_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a,
    input  logic [FACT_W-1:0] factor,
    input  logic              out_ready,
    output logic              b,
    output logic [PEND_W-1:0] pending,
    output logic              busy,
    output logic              overflow
);

    // The sum of the backlog and a new burst must not wrap, so it gets its own width.
    localparam int TOT_W = $clog2(MAX_PENDING + MAX_FACTOR + 1);

    // Clamp the raw factor to 1..MAX_FACTOR: zero acts as one, and values
    // above MAX_FACTOR saturate.
    function automatic logic [TOT_W-1:0] clamp_factor(input logic [FACT_W-1:0] f);
        logic [TOT_W-1:0] r;
        if (f == {FACT_W{1'b0}}) begin
            r = TOT_W'(1'b1);
        end else if (f > FACT_W'(MAX_FACTOR)) begin
            r = TOT_W'(MAX_FACTOR);
        end else begin
            r = TOT_W'(f);
        end
        return r;
    endfunction

    logic [PEND_W-1:0] pend_r;
    logic              ovf_r;
    logic [TOT_W-1:0]  fe_s;
    logic              acc_s;
    logic [TOT_W-1:0]  total_s;
    logic              b_s;
    logic [TOT_W-1:0]  next_s;
    logic              over_s;

    // Work out this cycle's token total, the emitted token and the backlog that remains.
    always_comb begin
        fe_s    = clamp_factor(factor);
        acc_s   = a & ~ovf_r;
        total_s = TOT_W'(pend_r);
        if (acc_s) begin
            total_s = TOT_W'(pend_r) + fe_s;
        end else begin
            total_s = TOT_W'(pend_r);
        end
        b_s    = out_ready & (total_s != {TOT_W{1'b0}});
        next_s = total_s - TOT_W'(b_s);
        over_s = (next_s > TOT_W'(MAX_PENDING)) & ~ovf_r;
    end

    // Update the backlog register and the sticky overflow flag. On overflow,
    // the backlog saturates at MAX_PENDING.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r <= {PEND_W{1'b0}};
            ovf_r  <= 1'b0;
        end else if (over_s) begin
            pend_r <= PEND_W'(MAX_PENDING);
            ovf_r  <= 1'b1;
        end else begin
            pend_r <= next_s[PEND_W-1:0];
            ovf_r  <= ovf_r;
        end
    end

    assign b        = b_s;
    assign pending  = pend_r;
    assign busy     = (pend_r != {PEND_W{1'b0}});
    assign overflow = ovf_r;

endmodule
